// File: rtl/seq_alu_acc.sv
// Accumulator ALU with start/busy/done handshake.
// Logic, shift and add ops finish in one cycle; MUL and DIV take one bit per clock.
module seq_alu_acc #(
    parameter int N  = 16,
    parameter int SW = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [N-1:0] a_in,
    input  logic [N-1:0] b_in,
    input  logic [1:0]   b_src,
    output logic [N-1:0] acc,
    output logic         busy,
    output logic         done,
    output logic         zero,
    output logic         cout,
    output logic         div0
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_NAND = 4'd1;
    localparam logic [3:0] OP_OR   = 4'd2;
    localparam logic [3:0] OP_NOR  = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_XNOR = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_ADD  = 4'd8;
    localparam logic [3:0] OP_SUB  = 4'd9;
    localparam logic [3:0] OP_MUL  = 4'd10;
    localparam logic [3:0] OP_DIV  = 4'd11;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  x_q, x_d;
    logic [N-1:0]  y_q, y_d;
    logic [N-1:0]  w_q, w_d;
    logic          div_q, div_d;
    logic [N-1:0]  acc_q, acc_d;
    logic          done_q, done_d;
    logic          zero_q, zero_d;
    logic          cout_q, cout_d;
    logic          div0_q, div0_d;

    logic [N-1:0]  b_sel;
    logic [N-1:0]  alu_res;
    logic          alu_cy;
    logic [N:0]    sum_w;
    logic [N:0]    diff_w;
    logic [SW-1:0] shamt;
    logic          sh_ok;

    logic [N-1:0]  x_n, y_n, w_n, step_res;
    logic [N-1:0]  mul_w;
    logic [N:0]    rem_sh;
    logic [N:0]    rem_diff;
    logic          rem_ge;

    always_comb begin
        unique case (b_src)
            2'b01:   b_sel = acc_q;
            2'b10:   b_sel = '0;
            default: b_sel = b_in;
        endcase
    end

    always_comb begin
        alu_res = '0;
        alu_cy  = 1'b0;
        sum_w   = {1'b0, a_in} + {1'b0, b_sel};
        diff_w  = {1'b0, a_in} - {1'b0, b_sel};
        shamt   = b_sel[SW-1:0];
        sh_ok   = ({{(32-SW){1'b0}}, shamt} < 32'(N));
        unique case (op)
            OP_AND:  alu_res = a_in & b_sel;
            OP_NAND: alu_res = ~(a_in & b_sel);
            OP_OR:   alu_res = a_in | b_sel;
            OP_NOR:  alu_res = ~(a_in | b_sel);
            OP_XOR:  alu_res = a_in ^ b_sel;
            OP_XNOR: alu_res = ~(a_in ^ b_sel);
            OP_SHL:  alu_res = sh_ok ? (a_in << shamt) : '0;
            OP_SHR:  alu_res = sh_ok ? (a_in >> shamt) : '0;
            OP_ADD: begin
                alu_res = sum_w[N-1:0];
                alu_cy  = sum_w[N];
            end
            OP_SUB: begin
                alu_res = diff_w[N-1:0];
                alu_cy  = diff_w[N];
            end
            default: alu_res = '0;
        endcase
    end

    // x: multiplicand / dividend-becoming-quotient, y: multiplier / divisor,
    // w: partial product / partial remainder
    always_comb begin
        mul_w    = y_q[0] ? (w_q + x_q) : w_q;
        rem_sh   = {w_q, x_q[N-1]};
        rem_ge   = (rem_sh >= {1'b0, y_q});
        rem_diff = rem_sh - {1'b0, y_q};
        if (div_q) begin
            w_n      = rem_ge ? rem_diff[N-1:0] : rem_sh[N-1:0];
            x_n      = {x_q[N-2:0], rem_ge};
            y_n      = y_q;
            step_res = x_n;
        end else begin
            w_n      = mul_w;
            x_n      = x_q << 1;
            y_n      = y_q >> 1;
            step_res = mul_w;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        div_d   = div_q;
        acc_d   = acc_q;
        zero_d  = zero_q;
        cout_d  = cout_q;
        div0_d  = div0_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    done_d = 1'b1;
                    if (op == OP_MUL || (op == OP_DIV && b_sel != '0)) begin
                        state_d = S_RUN;
                        done_d  = 1'b0;
                        cnt_d   = '0;
                        x_d     = a_in;
                        y_d     = b_sel;
                        w_d     = '0;
                        div_d   = (op == OP_DIV);
                    end else if (op == OP_DIV) begin
                        acc_d  = '1;
                        zero_d = 1'b0;
                        cout_d = 1'b0;
                        div0_d = 1'b1;
                    end else if (op <= OP_SUB) begin
                        acc_d  = alu_res;
                        zero_d = (alu_res == '0);
                        cout_d = alu_cy;
                    end
                end
            end
            S_RUN: begin
                x_d   = x_n;
                y_d   = y_n;
                w_d   = w_n;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    acc_d   = step_res;
                    zero_d  = (step_res == '0);
                    cout_d  = 1'b0;
                    done_d  = 1'b1;
                    if (div_q) begin
                        div0_d = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            div_q   <= 1'b0;
            acc_q   <= '0;
            done_q  <= 1'b0;
            zero_q  <= 1'b1;
            cout_q  <= 1'b0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            div_q   <= div_d;
            acc_q   <= acc_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
            cout_q  <= cout_d;
            div0_q  <= div0_d;
        end
    end

    assign acc  = acc_q;
    assign busy = (state_q == S_RUN);
    assign done = done_q;
    assign zero = zero_q;
    assign cout = cout_q;
    assign div0 = div0_q;

endmodule

// File: tb/tb_seq_alu_acc.sv
// Bench for seq_alu_acc: directed vector table, hand-written corner sequences
// and random ops against an arithmetic reference model.
module tb_seq_alu_acc;

    localparam int N  = 16;
    localparam int SW = 5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   op;
    logic [N-1:0] a_in;
    logic [N-1:0] b_in;
    logic [1:0]   b_src;
    logic [N-1:0] acc;
    logic         busy;
    logic         done;
    logic         zero;
    logic         cout;
    logic         div0;

    seq_alu_acc #(.N(N), .SW(SW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .a_in  (a_in),
        .b_in  (b_in),
        .b_src (b_src),
        .acc   (acc),
        .busy  (busy),
        .done  (done),
        .zero  (zero),
        .cout  (cout),
        .div0  (div0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] m_acc;
    logic        m_zero;
    logic        m_cout;
    logic        m_div0;
    int          m_lat;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  bs;
        logic [15:0] exp;
        logic        ez;
        logic        ec;
        logic        ed;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic model_reset();
        m_acc  = 16'h0000;
        m_zero = 1'b1;
        m_cout = 1'b0;
        m_div0 = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] wide;
        logic [15:0] r;
        logic        c;
        bit          wr;
        int          amt;
        m_lat = 0;
        amt   = int'(b[4:0]);
        wr    = 1;
        c     = 1'b0;
        r     = '0;
        case (o)
            4'd0: r = a & b;
            4'd1: r = ~(a & b);
            4'd2: r = a | b;
            4'd3: r = ~(a | b);
            4'd4: r = a ^ b;
            4'd5: r = ~(a ^ b);
            4'd6: r = (amt >= 16) ? 16'h0 : 16'(a << amt);
            4'd7: r = (amt >= 16) ? 16'h0 : (a >> amt);
            4'd8: begin
                wide = 32'(a) + 32'(b);
                r    = wide[15:0];
                c    = wide[16];
            end
            4'd9: begin
                r = a - b;
                c = (a < b);
            end
            4'd10: begin
                wide  = 32'(a) * 32'(b);
                r     = wide[15:0];
                m_lat = N;
            end
            4'd11: begin
                if (b == 0) begin
                    r      = 16'hFFFF;
                    m_div0 = 1'b1;
                end else begin
                    r      = a / b;
                    m_div0 = 1'b0;
                    m_lat  = N;
                end
            end
            default: wr = 0;
        endcase
        if (wr) begin
            m_acc  = r;
            m_zero = (r == 0);
            m_cout = c;
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [15:0] a,
                         input logic [15:0] b, input logic [1:0] bs);
        @(negedge clk);
        op    = o;
        a_in  = a;
        b_in  = b;
        b_src = bs;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a_in  = 16'($urandom);
        b_in  = 16'($urandom);
        b_src = 2'($urandom);
    endtask

    task automatic wait_done(output int c, output int bc);
        c  = 0;
        bc = 0;
        while (!done && c < 64) begin
            if (busy) bc++;
            @(negedge clk);
            c++;
        end
    endtask

    task automatic run_op(input string nm, input logic [3:0] o, input logic [15:0] a,
                          input logic [15:0] b, input logic [1:0] bs);
        logic [15:0] b_eff;
        int          c;
        int          bc;
        b_eff = (bs == 2'b01) ? m_acc : (bs == 2'b10) ? 16'h0 : b;
        model_step(o, a, b_eff);
        issue(o, a, b, bs);
        wait_done(c, bc);
        chk({nm, " latency"}, c, m_lat);
        chk({nm, " busy cycles"}, bc, m_lat);
        chk({nm, " busy at done"}, busy, 0);
        chk({nm, " acc"}, acc, m_acc);
        chk({nm, " zero"}, zero, m_zero);
        chk({nm, " cout"}, cout, m_cout);
        chk({nm, " div0"}, div0, m_div0);
        @(negedge clk);
        chk({nm, " done pulse width"}, done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int dcnt;
        int first;

        vecs[0]  = '{4'd0,  16'hFFFF, 16'h0000, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4'd6,  16'h000B, 16'h0005, 2'b00, 16'h0160, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{4'd8,  16'hFFFF, 16'h0001, 2'b00, 16'h0000, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{4'd8,  16'h0001, 16'h7777, 2'b01, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{4'd8,  16'h0001, 16'h7777, 2'b01, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{4'd8,  16'h0001, 16'h7777, 2'b01, 16'h0003, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{4'd9,  16'h0003, 16'h0005, 2'b00, 16'hFFFE, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{4'd5,  16'h00FF, 16'h0F0F, 2'b11, 16'hF00F, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{4'd7,  16'h8000, 16'h0010, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{4'd3,  16'h0000, 16'h1234, 2'b10, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{4'd10, 16'h0003, 16'h0003, 2'b00, 16'h0009, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{4'd10, 16'h0100, 16'h0100, 2'b00, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{4'd11, 16'h0064, 16'h0007, 2'b00, 16'h000E, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{4'd11, 16'h1234, 16'h0000, 2'b00, 16'hFFFF, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{4'd1,  16'hF0F0, 16'h0000, 2'b01, 16'h0F0F, 1'b0, 1'b0, 1'b1};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 4'd0;
        a_in  = '0;
        b_in  = '0;
        b_src = 2'b00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("reset acc", acc, 16'h0000);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset zero", zero, 1);
        chk("reset cout", cout, 0);
        chk("reset div0", div0, 0);

        foreach (vecs[i]) begin
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].bs);
            chk($sformatf("vec%0d table acc", i), acc, vecs[i].exp);
            chk($sformatf("vec%0d table zero", i), zero, vecs[i].ez);
            chk($sformatf("vec%0d table cout", i), cout, vecs[i].ec);
            chk($sformatf("vec%0d table div0", i), div0, vecs[i].ed);
        end

        run_op("nop", 4'd13, 16'h5555, 16'h1111, 2'b00);
        chk("nop keeps acc", acc, 16'h0F0F);

        run_op("add before reset", 4'd8, 16'hFFFF, 16'h0002, 2'b00);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("midstream reset acc", acc, 16'h0000);
        chk("midstream reset busy", busy, 0);
        chk("midstream reset done", done, 0);
        chk("midstream reset zero", zero, 1);
        chk("midstream reset cout", cout, 0);

        model_step(4'd10, 16'h0003, 16'h0003);
        issue(4'd10, 16'h0003, 16'h0003, 2'b00);
        op    = 4'd8;
        a_in  = 16'h0001;
        b_in  = 16'h0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt  = 0;
        first = -1;
        for (int k = 1; k <= 24; k++) begin
            if (done) begin
                dcnt++;
                if (first < 0) first = k;
                chk("no done while busy", busy, 0);
            end
            @(negedge clk);
        end
        chk("mul ignore start done count", dcnt, 1);
        chk("mul ignore start done cycle", first, N);
        chk("mul ignore start acc", acc, 16'h0009);

        issue(4'd10, 16'h1234, 16'h0005, 2'b00);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("abort busy", busy, 0);
        chk("abort acc", acc, 16'h0000);
        chk("abort zero", zero, 1);
        dcnt = 0;
        for (int k = 0; k < 24; k++) begin
            if (done) dcnt++;
            @(negedge clk);
        end
        chk("abort no done", dcnt, 0);
        run_op("add after abort", 4'd8, 16'h0002, 16'h0003, 2'b00);
        chk("add after abort acc", acc, 16'h0005);

        for (int i = 0; i < 300; i++) begin
            logic [3:0]  ro;
            logic [15:0] ra;
            logic [15:0] rb;
            ro = 4'($urandom_range(0, 15));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, 2'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
